// File: rtl/cl2_csr_reg_pkg.sv
// Shared CSR layouts, trap FSM states and trap constants for the cl2 machine-mode trap logic.
package cl2_csr_reg_pkg;

  localparam int unsigned CAUSE_W = 5;

  typedef enum logic [1:0] {IDLE, FLUSH, COMMIT} cl2_trap_state_e;

  typedef struct packed {
    logic [18:0] rsvd_hi;
    logic [1:0]  mpp;
    logic [2:0]  rsvd_mid;
    logic        mpie;
    logic [2:0]  rsvd_lo;
    logic        mie;
    logic [2:0]  rsvd_low;
  } cl2_csr_mstatus_reg_t;

  typedef struct packed {
    logic [19:0] rsvd_hi;
    logic        meie;
    logic [2:0]  rsvd_mid;
    logic        mtie;
    logic [2:0]  rsvd_lo;
    logic        msie;
    logic [2:0]  rsvd_low;
  } cl2_csr_mie_reg_t;

  typedef struct packed {
    logic [19:0] rsvd_hi;
    logic        meip;
    logic [2:0]  rsvd_mid;
    logic        mtip;
    logic [2:0]  rsvd_lo;
    logic        msip;
    logic [2:0]  rsvd_low;
  } cl2_csr_mip_reg_t;

  typedef struct packed {
    logic        irq;
    logic [30:0] code;
  } cl2_csr_mcause_reg_t;

  localparam logic [CAUSE_W-1:0] IRQ_CODE_MEI = 5'd11;
  localparam logic [CAUSE_W-1:0] IRQ_CODE_MSI = 5'd3;
  localparam logic [CAUSE_W-1:0] IRQ_CODE_MTI = 5'd7;

  localparam logic [1:0] MTVEC_DIRECT   = 2'd0;
  localparam logic [1:0] MTVEC_VECTORED = 2'd1;
  localparam logic [1:0] MPP_MACHINE    = 2'b11;

endpackage

// File: rtl/cl2_irq_prio.sv
// Fixed-priority interrupt encoder: MEI > MSI > MTI.
module cl2_irq_prio
  import cl2_csr_reg_pkg::*;
(
  input  logic               meip,
  input  logic               msip,
  input  logic               mtip,
  output logic               valid_c,
  output logic [CAUSE_W-1:0] code_c
);

  always_comb begin
    valid_c = 1'b0;
    code_c  = '0;
    if (meip) begin
      valid_c = 1'b1;
      code_c  = IRQ_CODE_MEI;
    end else if (msip) begin
      valid_c = 1'b1;
      code_c  = IRQ_CODE_MSI;
    end else if (mtip) begin
      valid_c = 1'b1;
      code_c  = IRQ_CODE_MTI;
    end
  end

endmodule

// File: rtl/cl2_trap_ctrl.sv
// Machine-mode trap sequencer: arbitrates exceptions, mret and interrupts, runs the
// pipeline flush handshake and commits trap CSR updates with a one-cycle redirect.
module cl2_trap_ctrl
  import cl2_csr_reg_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter bit          VECTORED_EN = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 exc_valid_i,
  input  logic [CAUSE_W-1:0]   exc_cause_i,
  input  logic [XLEN-1:0]      exc_pc_i,
  input  logic [XLEN-1:0]      exc_tval_i,
  input  logic                 mret_valid_i,
  input  logic                 meip_i,
  input  logic                 mtip_i,
  input  logic                 msip_i,
  input  cl2_csr_mie_reg_t     csr_mie_i,
  input  logic [XLEN-1:0]      mtvec_i,
  input  logic                 csr_wr_i,
  input  logic [1:0]           csr_sel_i,
  input  logic [XLEN-1:0]      csr_wdata_i,
  output logic                 flush_req_o,
  input  logic                 flush_ack_i,
  output logic                 redirect_o,
  output logic [XLEN-1:0]      redirect_pc_o,
  output logic                 busy_o,
  output cl2_csr_mstatus_reg_t mstatus_o,
  output cl2_csr_mip_reg_t     mip_o,
  output logic [XLEN-1:0]      mepc_o,
  output logic [XLEN-1:0]      mcause_o,
  output logic [XLEN-1:0]      mtval_o
);

  cl2_trap_state_e    state;
  logic               lat_irq;
  logic               lat_mret;
  logic [CAUSE_W-1:0] lat_cause;
  logic [XLEN-1:0]    lat_pc;
  logic [XLEN-1:0]    lat_tval;

  logic               irq_valid_c;
  logic [CAUSE_W-1:0] irq_code_c;
  logic [XLEN-1:0]    base_c;
  logic [XLEN-1:0]    target_c;

  cl2_irq_prio u_irq_prio (
    .meip    (mip_o.meip & csr_mie_i.meie & mstatus_o.mie),
    .msip    (mip_o.msip & csr_mie_i.msie & mstatus_o.mie),
    .mtip    (mip_o.mtip & csr_mie_i.mtie & mstatus_o.mie),
    .valid_c (irq_valid_c),
    .code_c  (irq_code_c)
  );

  // Redirect target: mepc for mret, otherwise mtvec base with optional vector offset.
  always_comb begin
    base_c   = mtvec_i & ~XLEN'(3);
    target_c = base_c;
    if (lat_mret) begin
      target_c = mepc_o;
    end else if (VECTORED_EN && (mtvec_i[1:0] == MTVEC_VECTORED) && lat_irq) begin
      target_c = base_c + (XLEN'(lat_cause) << 2);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mip_o <= '0;
    end else begin
      mip_o      <= '0;
      mip_o.meip <= meip_i;
      mip_o.mtip <= mtip_i;
      mip_o.msip <= msip_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state         <= IDLE;
      lat_irq       <= 1'b0;
      lat_mret      <= 1'b0;
      lat_cause     <= '0;
      lat_pc        <= '0;
      lat_tval      <= '0;
      flush_req_o   <= 1'b0;
      redirect_o    <= 1'b0;
      redirect_pc_o <= '0;
      busy_o        <= 1'b0;
      mstatus_o     <= '0;
      mstatus_o.mpp <= MPP_MACHINE;
      mepc_o        <= '0;
      mcause_o      <= '0;
      mtval_o       <= '0;
    end else begin
      redirect_o <= 1'b0;

      // Software CSR writes lose to the trap commit in the same cycle.
      if (csr_wr_i && (state != COMMIT)) begin
        case (csr_sel_i)
          2'd0: begin
            mstatus_o.mie  <= csr_wdata_i[3];
            mstatus_o.mpie <= csr_wdata_i[7];
          end
          2'd1:    mepc_o   <= csr_wdata_i & ~XLEN'(3);
          2'd2:    mcause_o <= csr_wdata_i;
          default: mtval_o  <= csr_wdata_i;
        endcase
      end

      case (state)
        IDLE: begin
          if (exc_valid_i || mret_valid_i || irq_valid_c) begin
            state       <= FLUSH;
            flush_req_o <= 1'b1;
            busy_o      <= 1'b1;
            lat_irq     <= 1'b0;
            lat_mret    <= 1'b0;
            lat_pc      <= exc_pc_i;
            lat_cause   <= exc_cause_i;
            lat_tval    <= exc_tval_i;
            if (!exc_valid_i && mret_valid_i) begin
              lat_mret <= 1'b1;
            end else if (!exc_valid_i) begin
              lat_irq   <= 1'b1;
              lat_cause <= irq_code_c;
              lat_tval  <= '0;
            end
          end
        end
        FLUSH: begin
          if (flush_ack_i) begin
            state         <= COMMIT;
            flush_req_o   <= 1'b0;
            redirect_o    <= 1'b1;
            redirect_pc_o <= target_c;
          end
        end
        COMMIT: begin
          state         <= IDLE;
          busy_o        <= 1'b0;
          mstatus_o.mpp <= MPP_MACHINE;
          if (lat_mret) begin
            mstatus_o.mie  <= mstatus_o.mpie;
            mstatus_o.mpie <= 1'b1;
          end else begin
            mepc_o         <= lat_pc & ~XLEN'(3);
            mcause_o       <= {lat_irq, (XLEN-1)'(lat_cause)};
            mtval_o        <= lat_tval;
            mstatus_o.mpie <= mstatus_o.mie;
            mstatus_o.mie  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cl2_trap_ctrl.sv
// Directed self-checking bench for cl2_trap_ctrl.
module tb_cl2_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        exc_valid;
  logic [4:0]  exc_cause;
  logic [31:0] exc_pc;
  logic [31:0] exc_tval;
  logic        mret_valid;
  logic        meip, mtip, msip;
  logic [31:0] csr_mie;
  logic [31:0] mtvec;
  logic        csr_wr;
  logic [1:0]  csr_sel;
  logic [31:0] csr_wdata;
  logic        flush_req;
  logic        flush_ack;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        busy;
  logic [31:0] mstatus;
  logic [31:0] mip;
  logic [31:0] mepc;
  logic [31:0] mcause;
  logic [31:0] mtval;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cl2_trap_ctrl #(.XLEN(32), .VECTORED_EN(1'b1)) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .exc_valid_i   (exc_valid),
    .exc_cause_i   (exc_cause),
    .exc_pc_i      (exc_pc),
    .exc_tval_i    (exc_tval),
    .mret_valid_i  (mret_valid),
    .meip_i        (meip),
    .mtip_i        (mtip),
    .msip_i        (msip),
    .csr_mie_i     (csr_mie),
    .mtvec_i       (mtvec),
    .csr_wr_i      (csr_wr),
    .csr_sel_i     (csr_sel),
    .csr_wdata_i   (csr_wdata),
    .flush_req_o   (flush_req),
    .flush_ack_i   (flush_ack),
    .redirect_o    (redirect),
    .redirect_pc_o (redirect_pc),
    .busy_o        (busy),
    .mstatus_o     (mstatus),
    .mip_o         (mip),
    .mepc_o        (mepc),
    .mcause_o      (mcause),
    .mtval_o       (mtval)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_flush(input string tag);
    int n = 0;
    while (!flush_req && n < 10) begin
      step();
      n++;
    end
    chk(tag, 32'(flush_req), 32'd1);
  endtask

  task automatic csr_write(input logic [1:0] sel, input logic [31:0] data);
    csr_wr    = 1'b1;
    csr_sel   = sel;
    csr_wdata = data;
    step();
    csr_wr    = 1'b0;
  endtask

  // A new exception or mret must never be presented while the sequencer is busy.
  always @(negedge clk) begin
    if (rst_n) begin
      assert (!(busy && (exc_valid || mret_valid))) else begin
        n_fail++;
        $error("FAIL busy_event: exc/mret observed 1 while busy, expected 0");
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; exc_valid = 1'b0; exc_cause = '0; exc_pc = '0; exc_tval = '0;
    mret_valid = 1'b0; meip = 1'b0; mtip = 1'b0; msip = 1'b0; csr_mie = '0;
    mtvec = '0; csr_wr = 1'b0; csr_sel = '0; csr_wdata = '0; flush_ack = 1'b0;
    repeat (2) step();
    chk("rst_flush_req", 32'(flush_req), 32'd0);
    chk("rst_redirect", 32'(redirect), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mstatus", mstatus, 32'h0000_1800);
    chk("rst_mepc", mepc, 32'd0);
    chk("rst_mcause", mcause, 32'd0);
    chk("rst_mip", mip, 32'd0);
    rst_n = 1'b1;
    step();

    // mstatus write masking: only mie/mpie writable, mpp fixed at 11
    csr_write(2'd0, 32'hFFFF_FFFF);
    chk("mstatus_mask", mstatus, 32'h0000_1888);
    csr_write(2'd0, 32'h0000_0008);
    chk("mstatus_mie_set", mstatus, 32'h0000_1808);

    // T1: MEI, direct mtvec, ack three cycles late
    csr_mie = 32'h0000_0800; mtvec = 32'h0000_0100; exc_pc = 32'h0000_3000; meip = 1'b1;
    wait_flush("t1_flush_req");
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_mip", mip, 32'h0000_0800);
    repeat (3) step();
    chk("t1_flush_hold", 32'(flush_req), 32'd1);
    flush_ack = 1'b1;
    step();
    flush_ack = 1'b0;
    chk("t1_redirect", 32'(redirect), 32'd1);
    chk("t1_redirect_pc", redirect_pc, 32'h0000_0100);
    chk("t1_flush_drop", 32'(flush_req), 32'd0);
    step();
    chk("t1_redirect_pulse", 32'(redirect), 32'd0);
    chk("t1_busy_drop", 32'(busy), 32'd0);
    chk("t1_mcause", mcause, 32'h8000_000B);
    chk("t1_mepc", mepc, 32'h0000_3000);
    chk("t1_mtval", mtval, 32'd0);
    chk("t1_mstatus", mstatus, 32'h0000_1880);
    meip = 1'b0;
    step();

    // T2: MTI with vectored mtvec
    csr_write(2'd0, 32'h0000_0008);
    mtvec = 32'h0000_0101; csr_mie = 32'h0000_0080; exc_pc = 32'h0000_4000; mtip = 1'b1;
    wait_flush("t2_flush_req");
    flush_ack = 1'b1;
    step();
    flush_ack = 1'b0;
    chk("t2_redirect", 32'(redirect), 32'd1);
    chk("t2_redirect_pc", redirect_pc, 32'h0000_011C);
    mtip = 1'b0;
    step();
    chk("t2_mcause", mcause, 32'h8000_0007);
    chk("t2_mepc", mepc, 32'h0000_4000);
    chk("t2_mstatus", mstatus, 32'h0000_1880);
    step();

    // T3: exception wins against a simultaneously pending MEI
    csr_write(2'd0, 32'h0000_0008);
    csr_mie = 32'h0000_0800; meip = 1'b1;
    step();
    exc_valid = 1'b1; exc_cause = 5'd2; exc_pc = 32'h0000_2004; exc_tval = 32'h0000_DEAD;
    step();
    exc_valid = 1'b0;
    chk("t3_flush_req", 32'(flush_req), 32'd1);
    flush_ack = 1'b1;
    step();
    flush_ack = 1'b0;
    chk("t3_redirect_pc", redirect_pc, 32'h0000_0100);
    step();
    chk("t3_mcause", mcause, 32'h0000_0002);
    chk("t3_mepc", mepc, 32'h0000_2004);
    chk("t3_mtval", mtval, 32'h0000_DEAD);
    chk("t3_mstatus", mstatus, 32'h0000_1880);
    repeat (3) step();
    chk("t3_no_irq_busy", 32'(busy), 32'd0);
    chk("t3_no_irq_flush", 32'(flush_req), 32'd0);

    // T4: mret, then the still-pending MEI is taken; CSR write in COMMIT dropped
    exc_pc = 32'h0000_5000;
    csr_write(2'd1, 32'h0000_200B);
    chk("t4_mepc_wr", mepc, 32'h0000_2008);
    mret_valid = 1'b1;
    step();
    mret_valid = 1'b0;
    chk("t4_flush_req", 32'(flush_req), 32'd1);
    flush_ack = 1'b1;
    step();
    flush_ack = 1'b0;
    chk("t4_redirect_pc", redirect_pc, 32'h0000_2008);
    step();
    chk("t4_mstatus", mstatus, 32'h0000_1888);
    chk("t4_busy_drop", 32'(busy), 32'd0);
    wait_flush("t4_irq2_flush");
    flush_ack = 1'b1;
    step();
    flush_ack = 1'b0;
    chk("t4_irq2_redirect", 32'(redirect), 32'd1);
    chk("t4_irq2_redirect_pc", redirect_pc, 32'h0000_012C);
    csr_write(2'd2, 32'h0000_0055);
    chk("t4_mcause_kept", mcause, 32'h8000_000B);
    chk("t4_irq2_mepc", mepc, 32'h0000_5000);
    chk("t4_irq2_mstatus", mstatus, 32'h0000_1880);
    meip = 1'b0;
    step();

    // T5: asynchronous reset during FLUSH
    csr_write(2'd0, 32'h0000_0008);
    meip = 1'b1;
    wait_flush("t5_flush_req");
    rst_n = 1'b0;
    #1;
    chk("t5_rst_flush", 32'(flush_req), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_mstatus", mstatus, 32'h0000_1800);
    chk("t5_rst_mcause", mcause, 32'd0);
    meip = 1'b0; flush_ack = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("t5_no_redirect_a", 32'(redirect), 32'd0);
    step();
    chk("t5_no_redirect_b", 32'(redirect), 32'd0);
    chk("t5_idle", 32'(busy), 32'd0);
    flush_ack = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
